// File: rtl/button_gesture_decoder_pkg.sv
// Shared definitions for the button gesture decoder.
//   - One-hot state encoding (5 bits) for the gesture FSM.
//   - Default tick constants (1 ms tick at 50 MHz).
//   - Packed event struct for the registered pulse outputs.
package button_gesture_decoder_pkg;

  localparam int STATE_W = 5;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 5'b00001;
  localparam state_t ST_PRESS1 = 5'b00010;
  localparam state_t ST_WAIT2  = 5'b00100;
  localparam state_t ST_PRESS2 = 5'b01000;
  localparam state_t ST_LONG   = 5'b10000;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_LONG_TICKS   = 1000;
  localparam int DEF_DCLICK_TICKS = 250;

  // One bit per pulse output; 'rel' and 'lng' avoid SV keywords.
  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dclick;
    logic lng;
  } evt_t;

endpackage

// File: rtl/button_gesture_decoder_if.sv
// Signal bundle between the debounce stage / UI logic and the decoder.
//   signal_i : debounced button level (sysclk-synchronous)
//   press_o, release_o, click_o, dclick_o, long_o : one-cycle event pulses
//   held_o   : level, 1 while the button is pressed
//   state_o  : debug view of the gesture FSM state (one-hot)
// There is no valid/ready handshake: signal_i is sampled every cycle and
// every output is a registered pulse or level, valid in every cycle.
// slave  = the decoder, master = whoever drives the button and consumes events.
interface button_gesture_decoder_if;
  import button_gesture_decoder_pkg::*;

  logic   signal_i;
  logic   press_o;
  logic   release_o;
  logic   click_o;
  logic   dclick_o;
  logic   long_o;
  logic   held_o;
  state_t state_o;

  modport slave (
    input  signal_i,
    output press_o, release_o, click_o, dclick_o, long_o, held_o, state_o
  );

  modport master (
    output signal_i,
    input  press_o, release_o, click_o, dclick_o, long_o, held_o, state_o
  );
endinterface

// File: rtl/button_gesture_decoder_tick_gen.sv
// tick_gen: prescaler producing one tick every TICK_DIV sysclk cycles.
//   sysclk : clock
//   reset  : asynchronous active-high reset
//   clr_i  : synchronous clear, wins over counting
//   tick_o : high while the prescaler sits at its terminal count
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (clr_i) begin
      r_pre <= '0;
    end else if (r_pre == TERM) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Tick is seen on the TICK_DIV-th edge after a clear.
  assign tick_o = (r_pre == TERM);
endmodule

// File: rtl/button_gesture_decoder.sv
// button_gesture_decoder: turns a clean button level into registered
// press / release / click / double-click / long-press pulses and a held level.
//   sysclk, reset : clock and asynchronous active-high reset
//   bus (slave)   : signal_i in; press_o, release_o, click_o, dclick_o,
//                   long_o, held_o, state_o out
// Thresholds are in prescaler ticks; the tick counter and prescaler restart
// on every FSM transition so each phase is timed from its own start.
module button_gesture_decoder
  import button_gesture_decoder_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                     sysclk,
  input  logic                     reset,
  button_gesture_decoder_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] DCLK_C  = CNT_W'(DCLICK_TICKS);

  logic             w_pressed, w_pe, w_re, w_tick, w_trans;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state, w_next;
  evt_t             r_evt, w_evt;

  assign w_pressed = bus.signal_i ^ ACTIVE_LOW;
  // r_prev resets to "not pressed" so an idle-level input never fakes an edge.
  assign w_pe = w_pressed & ~r_prev;
  assign w_re = ~w_pressed & r_prev;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .clr_i  (w_trans),
    .tick_o (w_tick)
  );

  // Edges are tested before thresholds so an edge always wins a tie.
  always_comb begin
    w_next       = r_state;
    w_evt        = '0;
    w_evt.press  = w_pe;
    w_evt.rel    = w_re;
    case (r_state)
      ST_IDLE: begin
        if (w_pe) w_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (w_re) begin
          w_next = ST_WAIT2;
        end else if (r_cnt == LONG_C) begin
          w_next    = ST_LONG;
          w_evt.lng = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (w_pe) begin
          w_next = ST_PRESS2;
        end else if (r_cnt == DCLK_C) begin
          w_next      = ST_IDLE;
          w_evt.click = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (w_re) begin
          w_next       = ST_IDLE;
          w_evt.dclick = 1'b1;
        end else if (r_cnt == LONG_C) begin
          w_next    = ST_LONG;
          w_evt.lng = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_re) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_trans = (w_next != r_state);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
      r_evt   <= '0;
    end else begin
      r_state <= w_next;
      r_prev  <= w_pressed;
      r_evt   <= w_evt;
      if (w_trans) begin
        r_cnt <= '0;
      end else if (w_tick && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.press_o   = r_evt.press;
  assign bus.release_o = r_evt.rel;
  assign bus.click_o   = r_evt.click;
  assign bus.dclick_o  = r_evt.dclick;
  assign bus.long_o    = r_evt.lng;
  assign bus.held_o    = r_prev;
  assign bus.state_o   = r_state;
endmodule

// File: tb/tb_button_gesture_decoder.sv
module tb_button_gesture_decoder;
  localparam int DIV = 4;
  localparam int LT  = 5;
  localparam int DT  = 3;
  // Gesture timing in cycles, measured from the edge that starts a phase.
  localparam int LONG_CYC = LT * DIV + 1;
  localparam int DCLK_CYC = DT * DIV + 1;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  always #5 sysclk = ~sysclk;

  button_gesture_decoder_if bus ();

  button_gesture_decoder #(
    .TICK_DIV(DIV), .CNT_W(16), .LONG_TICKS(LT), .DCLICK_TICKS(DT), .ACTIVE_LOW(1'b1)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  logic [5:0] exp_q[$];

  int n_press, n_rel, n_click, n_dclick, n_long, n_held, n_any;
  int t_press, t_rel, t_click, t_dclick, t_long;

  // {press, release, click, dclick, long, held}
  function automatic logic [5:0] dut_vec();
    return {bus.press_o, bus.release_o, bus.click_o, bus.dclick_o, bus.long_o, bus.held_o};
  endfunction

  task automatic chk_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (p,r,c,dc,l,h) cycle %0d", name, act, exp, ncyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    n_press = 0; n_rel = 0; n_click = 0; n_dclick = 0; n_long = 0; n_held = 0; n_any = 0;
    t_press = -1; t_rel = -1; t_click = -1; t_dclick = -1; t_long = -1;
  endtask

  // ---------------- behavioural model ----------------
  // Gesture phases: 0 idle, 1 first press, 2 gap after first release,
  // 3 second press, 4 long hold. Timeouts are absolute edge numbers.
  int    m_phase    = 0;
  bit    m_prev     = 1'b0;
  int    m_edge     = 0;
  int    m_deadline = 0;

  always @(posedge sysclk or posedge reset) begin
    bit p, pe, re;
    logic [5:0] e;
    if (reset) begin
      m_phase = 0;
      m_prev  = 1'b0;
      m_edge  = 0;
      exp_q.delete();
    end else begin
      m_edge++;
      p  = ~bus.signal_i;
      pe = p & ~m_prev;
      re = ~p & m_prev;
      e  = '0;
      e[5] = pe;
      e[4] = re;
      case (m_phase)
        0: if (pe) begin m_phase = 1; m_deadline = m_edge + LONG_CYC; end
        1, 3: begin
          if (re) begin
            if (m_phase == 1) begin m_phase = 2; m_deadline = m_edge + DCLK_CYC; end
            else begin m_phase = 0; e[2] = 1'b1; end
          end else if (m_edge >= m_deadline) begin
            m_phase = 4; e[1] = 1'b1;
          end
        end
        2: begin
          if (pe) begin m_phase = 3; m_deadline = m_edge + LONG_CYC; end
          else if (m_edge >= m_deadline) begin m_phase = 0; e[3] = 1'b1; end
        end
        default: if (re) m_phase = 0;
      endcase
      m_prev = p;
      e[0]   = p;
      exp_q.push_back(e);
    end
  end

  // ---------------- compare / event log ----------------
  always @(negedge sysclk) begin
    logic [5:0] a, e;
    ncyc++;
    a = dut_vec();
    if (reset) begin
      chk_vec("outs_in_reset", a, 6'b0);
    end else if (exp_q.size() == 0) begin
      chk_vec("model_queue_empty", a, 6'bx);
    end else begin
      e = exp_q.pop_front();
      chk_vec("cycle_outputs", a, e);
      if (a[5]) begin n_press++;  t_press  = ncyc; end
      if (a[4]) begin n_rel++;    t_rel    = ncyc; end
      if (a[3]) begin n_click++;  t_click  = ncyc; end
      if (a[2]) begin n_dclick++; t_dclick = ncyc; end
      if (a[1]) begin n_long++;   t_long   = ncyc; end
      if (a[0]) n_held++;
      if (a != 6'b0) n_any++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at negedge+1; the level is sampled by the next n rising edges.
  task automatic hold(input bit v, input int n);
    bus.signal_i = v;
    repeat (n) begin
      @(negedge sysclk);
      #1;
    end
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    #1;
    chk_vec("async_reset_clear", dut_vec(), 6'b0);
    repeat (n) @(negedge sysclk);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.signal_i = 1'b1;
    clear_log();
    #1 reset = 1'b1;
    repeat (3) @(negedge sysclk);
    #1 reset = 1'b0;

    // idle after reset
    clear_log();
    hold(1, 50);
    chk_int("idle_no_outputs", n_any, 0);

    // single click
    clear_log();
    hold(0, 8); hold(1, 30);
    chk_int("click_npress", n_press, 1);
    chk_int("click_nrel", n_rel, 1);
    chk_int("click_rel_delay", t_rel - t_press, 8);
    chk_int("click_count", n_click, 1);
    chk_int("click_delay", t_click - t_rel, 13);
    chk_int("click_no_dclick_long", n_dclick + n_long, 0);

    // double click
    clear_log();
    hold(0, 6); hold(1, 5); hold(0, 6); hold(1, 30);
    chk_int("dclick_npress", n_press, 2);
    chk_int("dclick_nrel", n_rel, 2);
    chk_int("dclick_count", n_dclick, 1);
    chk_int("dclick_with_release", t_dclick, t_rel);
    chk_int("dclick_no_click", n_click, 0);

    // long press
    clear_log();
    hold(0, 40); hold(1, 30);
    chk_int("long_count", n_long, 1);
    chk_int("long_delay", t_long - t_press, 21);
    chk_int("long_held_cycles", n_held, 40);
    chk_int("long_nrel", n_rel, 1);
    chk_int("long_no_click", n_click + n_dclick, 0);

    // release on the long-threshold cycle
    clear_log();
    hold(0, 21); hold(1, 30);
    chk_int("tie_long_absent", n_long, 0);
    chk_int("tie_click_count", n_click, 1);
    chk_int("tie_click_delay", t_click - t_rel, 13);

    // second press on the window-expiry cycle
    clear_log();
    hold(0, 4); hold(1, 13); hold(0, 4); hold(1, 30);
    chk_int("tie_win_click_absent", n_click, 0);
    chk_int("tie_win_dclick", n_dclick, 1);
    chk_int("tie_win_long_absent", n_long, 0);

    // reset while held, then reset while waiting for a second press
    hold(0, 3);
    pulse_reset(2);
    hold(1, 5);
    clear_log();
    hold(0, 4); hold(1, 5);
    bus.signal_i = 1'b1;
    pulse_reset(2);
    clear_log();
    hold(1, 30);
    chk_int("reset_wait2_no_click", n_click, 0);
    chk_int("reset_wait2_quiet", n_any, 0);

    // randomized gestures
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        pulse_reset($urandom_range(1, 3));
      end
      hold(i[0], $urandom_range(1, 28));
    end
    hold(1, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
